// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encoding, opcodes,
// datapath mux/ALU encodings and the per-cycle control vector.
package ctrl_pkg;

  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT, TRAP
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    SRCB_REG = 2'd0, SRCB_CONST2 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SHL1 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_OR = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
  } ctrl_vec_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Datapath-facing bundle of the control FSM. slave = FSM side,
// master = datapath side. out_Trap exists only with ILLEGAL_OPCODE_TRAP_EN.
interface multicycle_control_fsm_if #(parameter int CNT_WIDTH = 16);
  logic [3:0]           in_Opcode;
  logic                 in_Zero;
  logic                 in_MemReady;
  logic                 out_PCWrite;
  logic                 out_PCWriteCond;
  logic                 out_IorD;
  logic                 out_MemRead;
  logic                 out_MemWrite;
  logic                 out_IRWrite;
  logic                 out_RegWrite;
  logic                 out_MemToReg;
  logic                 out_ALUSrcA;
  logic [1:0]           out_ALUSrcB;
  logic [1:0]           out_ALUOp;
  logic [1:0]           out_PCSource;
  logic                 out_Halted;
  logic                 out_MemFault;
  logic [CNT_WIDTH-1:0] out_InstCount;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic                 out_Trap;
`endif

  modport slave (
    input  in_Opcode, in_Zero, in_MemReady,
    output out_PCWrite, out_PCWriteCond, out_IorD, out_MemRead, out_MemWrite,
           out_IRWrite, out_RegWrite, out_MemToReg, out_ALUSrcA, out_ALUSrcB,
           out_ALUOp, out_PCSource, out_Halted, out_MemFault, out_InstCount
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , output out_Trap
`endif
  );

  modport master (
    output in_Opcode, in_Zero, in_MemReady,
    input  out_PCWrite, out_PCWriteCond, out_IorD, out_MemRead, out_MemWrite,
           out_IRWrite, out_RegWrite, out_MemToReg, out_ALUSrcA, out_ALUSrcB,
           out_ALUOp, out_PCSource, out_Halted, out_MemFault, out_InstCount
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , input out_Trap
`endif
  );
endinterface

// File: rtl/ctrl_output_decode.sv
// State-to-control-vector map. FETCH qualifies its IR/PC load with the
// memory ready strobe; BRANCH qualifies the conditional PC load with the
// resolved branch condition. squash forces every control to 0.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       squash,
  input  logic       mem_ready,
  input  logic       branch_take,
  input  logic [1:0] opcode_lo,
  output ctrl_vec_t  ctrl
);

  // one control word per state
  always_comb begin
    ctrl = '0;
    if (!squash) begin
      case (state)
        FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_CONST2;
          ctrl.alu_op    = ALU_ADD;
          if (mem_ready) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_ALU;
          end
        end
        DECODE: ctrl.alu_src_b = SRCB_IMM_SHL1;
        EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = alu_op_t'(opcode_lo);
        end
        EXEC_I, MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        ALU_WB: ctrl.reg_write = 1'b1;
        MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REG;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.pc_write_cond = branch_take;
        end
        JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath control FSM with memory-ready timeout and retired
// instruction counter. Optional: ILLEGAL_OPCODE_TRAP_EN parks opcodes A-E
// in TRAP (out_Trap sticky until RST); otherwise they retire as NOPs.
//
// state    | meaning
// RESET    | post-reset idle cycle, controls 0
// FETCH    | read instruction, load IR/PC on ready
// DECODE   | dispatch, precompute branch target
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate add
// ALU_WB   | write ALUOut to register file
// MEM_ADDR | compute load/store address
// MEM_RD   | memory read, wait for ready
// MEM_WB   | write MDR to register file
// MEM_WR   | memory write, wait for ready
// BRANCH   | compare, conditional PC load
// JUMP     | unconditional PC load from jump target
// HALT     | parked (HALT opcode or memory timeout)
// TRAP     | parked on illegal opcode
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic                   CLK,
  input logic                   RST,
  multicycle_control_fsm_if.slave bus
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t               state;
  logic [7:0]           wait_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic                 mem_fault;
  logic                 is_bne;
  logic                 mem_wait_state;
  logic                 wait_expired;
  logic                 branch_take;
  ctrl_vec_t            ctrl;

  assign mem_wait_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // a ready strobe in the last allowed cycle still completes the access
  assign wait_expired   = mem_wait_state && !bus.in_MemReady && (wait_cnt == WAIT_LAST);
  assign branch_take    = is_bne ? !bus.in_Zero : bus.in_Zero;

  // next state, wait counter, retired-instruction counter, fault flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RESET;
      wait_cnt  <= '0;
      inst_cnt  <= '0;
      mem_fault <= 1'b0;
      is_bne    <= 1'b0;
    end else begin
      if (mem_wait_state && !bus.in_MemReady && !wait_expired)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;

      if (wait_expired) begin
        mem_fault <= 1'b1;
        state     <= HALT;
      end else begin
        case (state)
          RESET: state <= FETCH;
          FETCH: if (bus.in_MemReady) begin
            inst_cnt <= inst_cnt + 1'b1;
            state    <= DECODE;
          end
          DECODE: begin
            is_bne <= (bus.in_Opcode == OP_BNE);
            case (bus.in_Opcode)
              OP_ADD, OP_SUB, OP_AND, OP_OR: state <= EXEC_R;
              OP_ADDI:                       state <= EXEC_I;
              OP_LW, OP_SW:                  state <= MEM_ADDR;
              OP_BEQ, OP_BNE:                state <= BRANCH;
              OP_JMP:                        state <= JUMP;
              OP_HALT:                       state <= HALT;
`ifdef ILLEGAL_OPCODE_TRAP_EN
              default:                       state <= TRAP;
`else
              default:                       state <= FETCH;
`endif
            endcase
          end
          EXEC_R, EXEC_I: state <= ALU_WB;
          MEM_ADDR: state <= (bus.in_Opcode == OP_LW) ? MEM_RD : MEM_WR;
          MEM_RD:   if (bus.in_MemReady) state <= MEM_WB;
          MEM_WR:   if (bus.in_MemReady) state <= FETCH;
          ALU_WB, MEM_WB, BRANCH, JUMP: state <= FETCH;
          HALT:     state <= HALT;
          TRAP:     state <= TRAP;
          default:  state <= RESET;
        endcase
      end
    end
  end

  ctrl_output_decode u_decode (
    .state       (state),
    .squash      (RST),
    .mem_ready   (bus.in_MemReady),
    .branch_take (branch_take),
    .opcode_lo   (bus.in_Opcode[1:0]),
    .ctrl        (ctrl)
  );

  assign bus.out_PCWrite     = ctrl.pc_write;
  assign bus.out_PCWriteCond = ctrl.pc_write_cond;
  assign bus.out_IorD        = ctrl.i_or_d;
  assign bus.out_MemRead     = ctrl.mem_read;
  assign bus.out_MemWrite    = ctrl.mem_write;
  assign bus.out_IRWrite     = ctrl.ir_write;
  assign bus.out_RegWrite    = ctrl.reg_write;
  assign bus.out_MemToReg    = ctrl.mem_to_reg;
  assign bus.out_ALUSrcA     = ctrl.alu_src_a;
  assign bus.out_ALUSrcB     = ctrl.alu_src_b;
  assign bus.out_ALUOp       = ctrl.alu_op;
  assign bus.out_PCSource    = ctrl.pc_source;
  assign bus.out_Halted      = !RST && ((state == HALT) || (state == TRAP));
  assign bus.out_MemFault    = mem_fault;
  assign bus.out_InstCount   = inst_cnt;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign bus.out_Trap        = !RST && (state == TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Expected control words come from a
// per-instruction cycle plan built from the opcode's documented sequence.
module tb_multicycle_control_fsm;
  localparam int WL = 4;
  localparam int CW = 4;

  // control word layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // RegWrite MemToReg ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] Halted
  localparam logic [15:0] W_FWAIT = 16'h1020; // MemRead, SrcB=2-const
  localparam logic [15:0] W_FDONE = 16'h9420; // + IRWrite, PCWrite
  localparam logic [15:0] W_DEC   = 16'h0060; // SrcB=imm<<1
  localparam logic [15:0] W_EXR   = 16'h0080; // SrcA=reg, SrcB=reg, op added
  localparam logic [15:0] W_EXI   = 16'h00C0; // SrcA=reg, SrcB=imm
  localparam logic [15:0] W_AWB   = 16'h0200;
  localparam logic [15:0] W_MRD   = 16'h3000;
  localparam logic [15:0] W_MWB   = 16'h0300;
  localparam logic [15:0] W_MWR   = 16'h2800;
  localparam logic [15:0] W_BR    = 16'h008A; // sub, PCSource=ALUOut
  localparam logic [15:0] B_PCWC  = 16'h4000;
  localparam logic [15:0] W_JMP   = 16'h8004;
  localparam logic [15:0] W_HALT  = 16'h0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_WIDTH(CW)) bus();
  multicycle_control_fsm #(.WAIT_LIMIT(WL), .CNT_WIDTH(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rdy;
    logic [15:0] w;
  } step_t;

  step_t plan[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_cnt = 0;

  function automatic logic [15:0] obs_word();
    return {bus.out_PCWrite, bus.out_PCWriteCond, bus.out_IorD, bus.out_MemRead,
            bus.out_MemWrite, bus.out_IRWrite, bus.out_RegWrite, bus.out_MemToReg,
            bus.out_ALUSrcA, bus.out_ALUSrcB, bus.out_ALUOp, bus.out_PCSource,
            bus.out_Halted};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic [15:0] w);
    step_t s;
    s.rdy = r;
    s.w   = w;
    plan.push_back(s);
  endtask

  task automatic push_fetch(input int delay);
    for (int i = 0; i < delay; i++) push(1'b0, W_FWAIT);
    push(1'b1, W_FDONE);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  // one instruction from FETCH until it is back in FETCH (or parked)
  task automatic push_instr(input int op, input logic zero, input int df, input int dm);
    logic take;
    bus.in_Opcode = 4'(op);
    bus.in_Zero   = zero;
    push_fetch(df);
    push(rnd(), W_DEC);
    if (op <= 3) begin
      push(rnd(), W_EXR | (16'(op % 4) << 3));
      push(rnd(), W_AWB);
    end else if (op == 4) begin
      push(rnd(), W_EXI);
      push(rnd(), W_AWB);
    end else if (op == 5) begin
      push(rnd(), W_EXI);
      for (int i = 0; i < dm; i++) push(1'b0, W_MRD);
      push(1'b1, W_MRD);
      push(rnd(), W_MWB);
    end else if (op == 6) begin
      push(rnd(), W_EXI);
      for (int i = 0; i < dm; i++) push(1'b0, W_MWR);
      push(1'b1, W_MWR);
    end else if (op == 7 || op == 8) begin
      take = (op == 7) ? zero : !zero;
      push(rnd(), W_BR | (take ? B_PCWC : 16'h0));
    end else if (op == 9) begin
      push(rnd(), W_JMP);
    end else if (op == 15) begin
      repeat (3) push(rnd(), W_HALT);
    end else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
      repeat (3) push(rnd(), W_HALT);
`endif
    end
  endtask

  task automatic run_plan(input string tag);
    step_t s;
    int    k;
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      bus.in_MemReady = s.rdy;
      @(negedge clk);
      chk($sformatf("%s.cyc%0d", tag, k), 32'(obs_word()), 32'(s.w));
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic chk_status(input string tag, input logic fault);
    chk({tag, ".count"}, 32'(bus.out_InstCount), exp_cnt);
    chk({tag, ".fault"}, 32'(bus.out_MemFault), 32'(fault));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_ctrl"}, 32'(obs_word()), 32'h0);
    @(posedge clk);
    #1;
    exp_cnt = 0;
    chk_status({tag, ".rst"}, 1'b0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    chk({tag, ".rst_trap"}, 32'(bus.out_Trap), 32'h0);
`endif
    rst = 1'b0;
    push(rnd(), 16'h0);
    run_plan({tag, ".reset_state"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst             = 1'b1;
    bus.in_Opcode   = 4'h0;
    bus.in_Zero     = 1'b0;
    bus.in_MemReady = 1'b1;

    // reset held three cycles, then RESET cycle, ready tied high
    repeat (3) begin
      @(negedge clk);
      chk("reset.ctrl", 32'(obs_word()), 32'h0);
      @(posedge clk);
      #1;
    end
    chk_status("reset", 1'b0);
    rst = 1'b0;
    push(1'b1, 16'h0);
    run_plan("reset_state");

    push_instr(0, 1'b0, 0, 0);  run_plan("add");     chk_status("add", 1'b0);
    push_instr(5, 1'b0, 0, 3);  run_plan("lw_wait"); chk_status("lw_wait", 1'b0);
    push_instr(7, 1'b1, 1, 0);  run_plan("beq_z1");  chk_status("beq_z1", 1'b0);
    push_instr(8, 1'b1, 0, 0);  run_plan("bne_z1");  chk_status("bne_z1", 1'b0);
    push_instr(9, 1'b0, 2, 0);  run_plan("jmp");     chk_status("jmp", 1'b0);
    push_instr(6, 1'b0, 0, WL - 1); run_plan("sw_lim"); chk_status("sw_lim", 1'b0);
    push_instr(1, 1'b0, WL - 1, 0); run_plan("fetch_lim"); chk_status("fetch_lim", 1'b0);

    // fetch timeout
    for (int i = 0; i < WL; i++) push(1'b0, W_FWAIT);
    repeat (2) push(rnd(), W_HALT);
    run_plan("fetch_timeout");
    chk_status("fetch_timeout", 1'b1);
    do_reset("after_fetch_to");

    // store timeout
    bus.in_Opcode = 4'h6;
    push_fetch(0);
    push(rnd(), W_DEC);
    push(rnd(), W_EXI);
    for (int i = 0; i < WL; i++) push(1'b0, W_MWR);
    repeat (2) push(rnd(), W_HALT);
    run_plan("sw_timeout");
    chk_status("sw_timeout", 1'b1);
    do_reset("after_sw_to");

    // reset aborting a load in its write-back cycle
    bus.in_Opcode = 4'h5;
    push_fetch(0);
    push(rnd(), W_DEC);
    push(rnd(), W_EXI);
    push(1'b1, W_MRD);
    run_plan("lw_abort");
    do_reset("lw_abort");

    // illegal opcode C
`ifdef ILLEGAL_OPCODE_TRAP_EN
    push_instr(12, 1'b0, 0, 0); run_plan("illegal_c");
    chk("illegal_c.trap", 32'(bus.out_Trap), 32'h1);
    chk_status("illegal_c", 1'b0);
    do_reset("after_trap");
`else
    push_instr(12, 1'b0, 0, 0); run_plan("illegal_c");
    chk_status("illegal_c", 1'b0);
    push_instr(4, 1'b0, 0, 0);  run_plan("addi_after_c");
    chk_status("addi_after_c", 1'b0);
`endif

    // randomized instruction stream (counter wraps at 2^CW)
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 14);
`ifdef ILLEGAL_OPCODE_TRAP_EN
      if (op >= 10) op = op - 10;
`endif
      push_instr(op, rnd(), $urandom_range(0, WL - 1), $urandom_range(0, WL - 1));
      run_plan($sformatf("rnd%0d_op%0h", n, op));
      chk_status($sformatf("rnd%0d", n), 1'b0);
    end

    // HALT opcode parks until reset
    push_instr(15, 1'b0, 0, 0); run_plan("halt");
    chk_status("halt", 1'b0);
    do_reset("after_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
